// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared widths, ALU command codes and execute-stage FSM state
//               type for the 16-bit pipelined MIPS core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 3;
    localparam int CMD_W     = 3;
    localparam int MUL_STEPS = 16;
    localparam int CNT_W     = $clog2(MUL_STEPS);

    localparam logic [CMD_W-1:0] ALU_ADD = 3'd0;
    localparam logic [CMD_W-1:0] ALU_SUB = 3'd1;
    localparam logic [CMD_W-1:0] ALU_AND = 3'd2;
    localparam logic [CMD_W-1:0] ALU_OR  = 3'd3;
    localparam logic [CMD_W-1:0] ALU_XOR = 3'd4;
    localparam logic [CMD_W-1:0] ALU_SLT = 3'd5;
    localparam logic [CMD_W-1:0] ALU_SHL = 3'd6;
    localparam logic [CMD_W-1:0] ALU_MUL = 3'd7;

    // Execute-stage sequencer: IDLE accepts work, BUSY runs the multiplier.
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } ex_state_t;

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/mul_iter.sv
// ============================================================================
// Module      : mul_iter
// Description : Iterative shift-add multiplier. One partial-product step per
//               'step' cycle; 'product' presents the accumulator value after
//               the current step so the final result is available on the
//               cycle where 'last' is high.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_iter
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              step,
    output logic              last,
    output logic [DATA_W-1:0] product
);

    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0] r_mplier;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] w_acc_next;

    // Accumulator value after adding this step's partial product.
    always_comb begin
        w_acc_next = r_acc;
        if (r_mplier[0]) begin
            w_acc_next = r_acc + r_mcand;
        end
    end

    // Only the low 16 bits of the product are kept, so the multiplicand
    // simply shifts out of range instead of widening.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
        end else if (start) begin
            r_acc    <= '0;
            r_mcand  <= a;
            r_mplier <= b;
            r_count  <= '0;
        end else if (step) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + 1'b1;
        end
    end

    assign last    = (r_count == CNT_W'(MUL_STEPS - 1));
    assign product = w_acc_next;

endmodule : mul_iter

`default_nettype wire

// File: rtl/ex_stage.sv
// ============================================================================
// Module      : ex_stage
// Description : Execute stage. Single-cycle ALU for ADD..SHL, iterative MUL
//               via mul_iter with an upstream stall, and the registered
//               EX/MEM output bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_stage
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [15:0]       inst,
    input  logic [15:0]       read1,
    input  logic [15:0]       read2,
    input  logic              wr_en,
    input  logic [2:0]        alu_cmd,
    input  logic [2:0]        write_addr,
    output logic              stall,
    output logic              valid_out,
    output logic [15:0]       result,
    output logic [15:0]       inst_out,
    output logic              wr_en_out,
    output logic [2:0]        write_addr_out
);

    ex_state_t         r_state;
    logic [15:0]       r_mul_inst;
    logic              r_mul_wr_en;
    logic [2:0]        r_mul_waddr;

    logic [DATA_W-1:0] w_alu;
    logic              w_lt;
    logic              w_wr_en_q;
    logic              w_mul_start;
    logic              w_mul_step;
    logic              w_mul_last;
    logic [DATA_W-1:0] w_mul_product;

    assign w_lt = ($signed(read1) < $signed(read2));

    // Single-cycle ALU for every command except MUL.
    always_comb begin
        w_alu = '0;
        case (alu_cmd)
            ALU_ADD: w_alu = read1 + read2;
            ALU_SUB: w_alu = read1 - read2;
            ALU_AND: w_alu = read1 & read2;
            ALU_OR:  w_alu = read1 | read2;
            ALU_XOR: w_alu = read1 ^ read2;
            ALU_SLT: w_alu = {{(DATA_W-1){1'b0}}, w_lt};
            ALU_SHL: w_alu = read1 << read2[3:0];
            default: w_alu = '0;
        endcase
    end

    // r0 is hardwired to zero, so writes to it are suppressed here.
    assign w_wr_en_q   = wr_en & (write_addr != 3'd0);

    assign w_mul_start = (r_state == S_IDLE) & in_valid & (alu_cmd == ALU_MUL);
    assign w_mul_step  = (r_state == S_BUSY);

    // Hold upstream from MUL acceptance until the final iteration, so the
    // next instruction arrives exactly when the product is written out.
    assign stall = w_mul_start | (w_mul_step & ~w_mul_last);

    mul_iter u_mul_iter (
        .clk     (clk),
        .rst     (rst),
        .start   (w_mul_start),
        .a       (read1),
        .b       (read2),
        .step    (w_mul_step),
        .last    (w_mul_last),
        .product (w_mul_product)
    );

    // IDLE/BUSY sequencer and EX/MEM output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_mul_inst     <= '0;
            r_mul_wr_en    <= 1'b0;
            r_mul_waddr    <= '0;
            valid_out      <= 1'b0;
            result         <= '0;
            inst_out       <= '0;
            wr_en_out      <= 1'b0;
            write_addr_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && (alu_cmd == ALU_MUL)) begin
                        r_state     <= S_BUSY;
                        r_mul_inst  <= inst;
                        r_mul_wr_en <= w_wr_en_q;
                        r_mul_waddr <= write_addr;
                        valid_out   <= 1'b0;
                    end else if (in_valid) begin
                        valid_out      <= 1'b1;
                        result         <= w_alu;
                        inst_out       <= inst;
                        wr_en_out      <= w_wr_en_q;
                        write_addr_out <= write_addr;
                    end else begin
                        valid_out <= 1'b0;
                    end
                end
                S_BUSY: begin
                    if (w_mul_last) begin
                        r_state        <= S_IDLE;
                        valid_out      <= 1'b1;
                        result         <= w_mul_product;
                        inst_out       <= r_mul_inst;
                        wr_en_out      <= r_mul_wr_en;
                        write_addr_out <= r_mul_waddr;
                    end else begin
                        valid_out <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    valid_out <= 1'b0;
                end
            endcase
        end
    end

endmodule : ex_stage

`default_nettype wire

// File: tb/tb_ex_stage.sv
// ============================================================================
// Module      : tb_ex_stage
// Description : Self-checking bench for ex_stage: table of single-cycle ALU
//               vectors plus directed MUL, back-to-back and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] inst;
    logic [15:0] read1;
    logic [15:0] read2;
    logic        wr_en;
    logic [2:0]  alu_cmd;
    logic [2:0]  write_addr;
    logic        stall;
    logic        valid_out;
    logic [15:0] result;
    logic [15:0] inst_out;
    logic        wr_en_out;
    logic [2:0]  write_addr_out;

    int checks = 0;
    int errors = 0;

    ex_stage dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .inst           (inst),
        .read1          (read1),
        .read2          (read2),
        .wr_en          (wr_en),
        .alu_cmd        (alu_cmd),
        .write_addr     (write_addr),
        .stall          (stall),
        .valid_out      (valid_out),
        .result         (result),
        .inst_out       (inst_out),
        .wr_en_out      (wr_en_out),
        .write_addr_out (write_addr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [2:0]  cmd;
        logic [15:0] a;
        logic [15:0] b;
        logic        we;
        logic [2:0]  wa;
        logic [15:0] ins;
        logic [15:0] exp_res;
        logic        exp_we;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] cmd, input logic [15:0] a,
                         input logic [15:0] b, input logic we, input logic [2:0] wa,
                         input logic [15:0] ins);
        in_valid   = v;
        alu_cmd    = cmd;
        read1      = a;
        read2      = b;
        wr_en      = we;
        write_addr = wa;
        inst       = ins;
    endtask

    // Present a MUL in cycle T and check the stall / valid_out profile
    // through T+16; returns positioned in T+16 with the MUL still driven.
    task automatic mul_body(input logic [15:0] a, input logic [15:0] b, input logic [15:0] ins);
        drive(1'b1, 3'd7, a, b, 1'b1, 3'd5, ins);
        #1;
        chk("mul_stall_T", {31'b0, stall}, 32'd1);
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk($sformatf("mul_valid_T+%0d", k), {31'b0, valid_out}, 32'd0);
            chk($sformatf("mul_stall_T+%0d", k), {31'b0, stall}, (k <= 15) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        // cmd, a, b, we, wa, inst, expected result, expected wr_en_out
        vecs[0]  = '{3'd0, 16'hFFFF, 16'h0002, 1'b1, 3'd3, 16'h1001, 16'h0001, 1'b1};
        vecs[1]  = '{3'd1, 16'h0000, 16'h0001, 1'b1, 3'd1, 16'h1002, 16'hFFFF, 1'b1};
        vecs[2]  = '{3'd2, 16'hF0F0, 16'h3C3C, 1'b1, 3'd2, 16'h1003, 16'h3030, 1'b1};
        vecs[3]  = '{3'd3, 16'hF0F0, 16'h0F01, 1'b1, 3'd4, 16'h1004, 16'hFFF1, 1'b1};
        vecs[4]  = '{3'd4, 16'hAAAA, 16'hFFFF, 1'b1, 3'd6, 16'h1005, 16'h5555, 1'b1};
        vecs[5]  = '{3'd5, 16'h8000, 16'h0001, 1'b1, 3'd7, 16'h1006, 16'h0001, 1'b1};
        vecs[6]  = '{3'd5, 16'h0001, 16'h8000, 1'b1, 3'd7, 16'h1007, 16'h0000, 1'b1};
        vecs[7]  = '{3'd6, 16'h0003, 16'h0014, 1'b1, 3'd2, 16'h1008, 16'h0030, 1'b1};
        vecs[8]  = '{3'd6, 16'h0001, 16'h000F, 1'b1, 3'd2, 16'h1009, 16'h8000, 1'b1};
        vecs[9]  = '{3'd0, 16'h0005, 16'h0007, 1'b1, 3'd0, 16'h100A, 16'h000C, 1'b0};
        vecs[10] = '{3'd1, 16'h0005, 16'h0007, 1'b0, 3'd3, 16'h100B, 16'hFFFE, 1'b0};
        vecs[11] = '{3'd5, 16'hFFFF, 16'hFFFF, 1'b1, 3'd1, 16'h100C, 16'h0000, 1'b1};

        rst = 1'b1;
        drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0);
        tick();
        tick();
        rst = 1'b0;
        chk("rst_valid", {31'b0, valid_out}, 32'd0);
        chk("rst_result", {16'b0, result}, 32'd0);
        chk("rst_inst", {16'b0, inst_out}, 32'd0);
        chk("rst_we", {31'b0, wr_en_out}, 32'd0);
        chk("rst_wa", {29'b0, write_addr_out}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);

        // Single-cycle ops issued back to back.
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].we, vecs[i].wa, vecs[i].ins);
            #1;
            chk($sformatf("v%0d_stall", i), {31'b0, stall}, 32'd0);
            tick();
            chk($sformatf("v%0d_valid", i), {31'b0, valid_out}, 32'd1);
            chk($sformatf("v%0d_result", i), {16'b0, result}, {16'b0, vecs[i].exp_res});
            chk($sformatf("v%0d_we", i), {31'b0, wr_en_out}, {31'b0, vecs[i].exp_we});
            chk($sformatf("v%0d_wa", i), {29'b0, write_addr_out}, {29'b0, vecs[i].wa});
            chk($sformatf("v%0d_inst", i), {16'b0, inst_out}, {16'b0, vecs[i].ins});
        end

        // Bubble: no stall, valid_out drops.
        drive(1'b0, 3'd7, 16'h1234, 16'h5678, 1'b1, 3'd1, 16'h2000);
        #1;
        chk("bubble_stall", {31'b0, stall}, 32'd0);
        tick();
        chk("bubble_valid", {31'b0, valid_out}, 32'd0);

        // MUL 0x0123 x 0x0045 followed by a bubble.
        mul_body(16'h0123, 16'h0045, 16'h3001);
        tick();
        drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0);
        chk("mul1_valid", {31'b0, valid_out}, 32'd1);
        chk("mul1_result", {16'b0, result}, 32'h4E6F);
        chk("mul1_inst", {16'b0, inst_out}, 32'h3001);
        chk("mul1_we", {31'b0, wr_en_out}, 32'd1);
        chk("mul1_wa", {29'b0, write_addr_out}, 32'd5);
        #1;
        chk("mul1_stall_after", {31'b0, stall}, 32'd0);
        tick();
        chk("mul1_valid_once", {31'b0, valid_out}, 32'd0);

        // MUL 0xFFFF x 0xFFFF immediately followed by ADD 1+1.
        mul_body(16'hFFFF, 16'hFFFF, 16'h3002);
        tick();
        drive(1'b1, 3'd0, 16'h0001, 16'h0001, 1'b1, 3'd2, 16'h3003);
        chk("mul2_valid", {31'b0, valid_out}, 32'd1);
        chk("mul2_result", {16'b0, result}, 32'h0001);
        #1;
        chk("mul2_add_stall", {31'b0, stall}, 32'd0);
        tick();
        drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0);
        chk("mul2_add_valid", {31'b0, valid_out}, 32'd1);
        chk("mul2_add_result", {16'b0, result}, 32'h0002);
        chk("mul2_add_inst", {16'b0, inst_out}, 32'h3003);
        tick();

        // Reset in T+8 of a MUL abandons it.
        drive(1'b1, 3'd7, 16'h0123, 16'h0045, 1'b1, 3'd5, 16'h3004);
        for (int k = 1; k <= 8; k++) tick();
        chk("rstmul_stall_T+8", {31'b0, stall}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b1, 3'd0, 16'h0010, 16'h0020, 1'b1, 3'd6, 16'h3005);
        chk("rstmul_valid", {31'b0, valid_out}, 32'd0);
        chk("rstmul_result", {16'b0, result}, 32'd0);
        chk("rstmul_inst", {16'b0, inst_out}, 32'd0);
        chk("rstmul_we", {31'b0, wr_en_out}, 32'd0);
        chk("rstmul_wa", {29'b0, write_addr_out}, 32'd0);
        #1;
        chk("rstmul_stall", {31'b0, stall}, 32'd0);
        tick();
        drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0);
        chk("rstmul_add_valid", {31'b0, valid_out}, 32'd1);
        chk("rstmul_add_result", {16'b0, result}, 32'h0030);
        chk("rstmul_add_wa", {29'b0, write_addr_out}, 32'd6);
        tick();
        chk("rstmul_idle_valid", {31'b0, valid_out}, 32'd0);
        chk("rstmul_idle_stall", {31'b0, stall}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ex_stage

`default_nettype wire

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 16-bit pipelined MIPS core: consumes the ID/EX pipeline register outputs, computes the ALU result, and registers the result, write enable and write address toward the EX/MEM boundary. Single-cycle ops complete in one cycle. MUL is an iterative 16-step shift-add operation. While MUL runs, `stall` freezes the upstream ID/EX register and PC.

## Interface

Parameters: none (datapath fixed at 16 bits, register address at 3 bits).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: ID/EX holds a real instruction (0 = bubble).
- `inst` in 16: instruction word from ID/EX.
- `read1` in 16: operand A from ID/EX.
- `read2` in 16: operand B from ID/EX.
- `wr_en` in 1: register write request from ID/EX.
- `alu_cmd` in 3: operation code.
- `write_addr` in 3: destination register.
- `stall` out 1: combinational; upstream holds its contents while high.
- `valid_out` out 1: registered; output bundle is a completed instruction.
- `result` out 16: registered ALU result.
- `inst_out` out 16: registered instruction of the completed op.
- `wr_en_out` out 1: registered write enable.
- `write_addr_out` out 3: registered destination.

## Operation

- `alu_cmd` encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLT: signed compare; result 1 if `read1` < `read2`, else 0.
  - 6 SHL: `read1` << `read2[3:0]`.
  - 7 MUL: low 16 bits of the unsigned product.
- ADD and SUB wrap modulo 2^16. No flags.
- `wr_en_out` = `wr_en` AND (`write_addr` != 0), because r0 is hardwired zero.
- FSM states:
  - IDLE:
    - `in_valid` with cmd 0–6: output registers load the result and `valid_out` is 1 at the next edge. Stay in IDLE.
    - `in_valid` with cmd 7: latch operands, the `inst`/`wr_en`/`write_addr` metadata, and count=0; go to BUSY.
    - No valid input: `valid_out` is 0 at the next edge.
  - BUSY: one shift-add iteration per cycle and count increments.
    - Inputs are ignored; they still hold the MUL.
    - `valid_out` stays 0 while BUSY.
    - On the count==15 iteration, the output registers load the product and latched metadata with `valid_out`=1, and the FSM returns to IDLE.
- `stall` = (IDLE AND `in_valid` AND cmd==7) OR (BUSY AND count!=15).
- A reset mid-MUL abandons the operation: the FSM goes to IDLE, count to 0, and the partial product is discarded.

## Timing

- Reset values: `valid_out`=0, `result`=0, `inst_out`=0, `wr_en_out`=0, `write_addr_out`=0, FSM=IDLE. `stall`=0 in the cycle after reset.
- Single-cycle op presented in cycle T: outputs valid in T+1. Throughput is one per cycle.
- MUL presented in cycle T:
  - `stall` is high in T..T+15 and low in T+16.
  - ID/EX advances at the end of T+16.
  - Product valid in T+17 (`valid_out`=1 for exactly one cycle).
- An instruction presented in T+17, or an ID/EX bubble, follows with no gap. Back-to-back MULs are each 17 cycles apart at the output.
- Bubbles (`in_valid`=0) never assert `stall`.

## Structure

- Shared package `cpu_pkg`: the `alu_cmd` constants (ALU_ADD..ALU_MUL), data width 16, register-address width 3, MUL_STEPS=16.
- Sub-module `mul_iter`: the shift-add engine.
  - State: accumulator, multiplicand, multiplier, 4-bit step count.
  - Ports: `start`, `a`, `b`, `step`, `last`, `product`.
- `ex_stage` holds the IDLE/BUSY FSM, the combinational ALU for cmd 0–6, the output register and the stall logic.

## Test plan

- ADD 0xFFFF + 0x0002, dest r3, `wr_en`=1 -> next cycle `result`=0x0001, `wr_en_out`=1, `write_addr_out`=3, `valid_out`=1.
- SLT 0x8000 vs 0x0001 -> `result`=1. SHL 0x0003 by 0x0014 (amount 4) -> `result`=0x0030.
- MUL 0x0123 × 0x0045 at T -> `stall` high T..T+15 and low at T+16; `result`=0x4E6F with `valid_out`=1 only in T+17; `valid_out`=0 during T+1..T+16.
- MUL 0xFFFF × 0xFFFF followed immediately by ADD 1+1 -> product 0x0001 at T+17, then `result`=0x0002 at T+18.
- ADD with dest r0 and `wr_en`=1 -> `wr_en_out`=0, `result` still computed.
- `rst` asserted at T+8 of a MUL -> next cycle all outputs 0, `stall`=0; a fresh ADD is accepted with its result valid one cycle later.
